instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries; also the maximum of buffered plus in-flight fetches.
REQ-003 SHALL use one clock and synchronous active-high reset; ports as listed below.
REQ-004 SHALL have port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port `imem_req_valid`, output, 1 bit: fetch request valid.
REQ-007 SHALL have port `imem_req_ready`, input, 1 bit: memory accepts the request.
REQ-008 SHALL have port `imem_req_addr`, output, 32 bits: fetch byte address, word aligned.
REQ-009 SHALL have port `imem_rsp_valid`, input, 1 bit: response valid. Responses arrive in order, one per accepted request, at least 1 cycle after acceptance.
REQ-010 SHALL have port `imem_rsp_data`, input, 32 bits: instruction word.
REQ-011 SHALL have port `redirect_valid`, input, 1 bit: branch, jump or trap redirect.
REQ-012 SHALL have port `redirect_pc`, input, 32 bits: new fetch address.
REQ-013 SHALL have port `id_valid`, output, 1 bit: instruction available to the decode stage (decoder and immediate generator).
REQ-014 SHALL have port `id_ready`, input, 1 bit: decode stage accepts.
REQ-015 SHALL have port `id_instr`, output, 32 bits: instruction word.
REQ-016 SHALL have port `id_pc`, output, 32 bits: address of `id_instr`.

Function
REQ-017 SHALL assert `imem_req_valid` when all of the following hold: `rst`=0, `redirect_valid`=0, and (buffer occupancy + in-flight count) < DEPTH.
REQ-018 SHALL drive `imem_req_addr` = pc.
REQ-019 On handshake (`imem_req_valid` & `imem_req_ready`), SHALL set pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and in-flight +1, and SHALL push pc into a request-address queue.
REQ-020 On `imem_rsp_valid` with drop count 0, SHALL push {addr queue head, `imem_rsp_data`} into the buffer, with in-flight -1; same-cycle push and pop SHALL both take effect.
REQ-021 On `imem_rsp_valid` with drop count >0, SHALL discard the response, with drop count -1 and in-flight -1.
REQ-022 SHALL drive `id_valid` = buffer non-empty & !`redirect_valid`, with `id_instr`/`id_pc` from the buffer head; pop on `id_valid` & `id_ready`.
REQ-023 Buffer-to-decode latency: a response received in cycle N SHALL be presented in cycle N+1.
REQ-024 On `redirect_valid`, SHALL set pc <= {`redirect_pc`[31:2],2'b00}, flush the buffer and addr queue, and set drop count <= in-flight - `imem_rsp_valid`; no request is issued that cycle.
REQ-025 On a redirect while drop count >0, drop count SHALL accumulate correctly; redirect SHALL win over every simultaneous push or pop.
REQ-026 While `id_ready`=0, SHALL hold the buffer contents stable; issue stops via REQ-017, so the buffer never overflows.
REQ-027 SHALL have states derived from the counters, IDLE, FETCH, FULL and DRAIN (drop count >0); FETCH requests are issued in DRAIN.

Reset
REQ-028 During `rst`, SHALL hold `imem_req_valid`=0 and `id_valid`=0.
REQ-029 On the next edge, SHALL set pc=RESET_PC, buffer empty, in-flight=0, drop=0.
REQ-030 A reset mid-operation SHALL abandon in-flight requests; the memory is reset with the same `rst`.
REQ-031 SHALL assert `imem_req_valid` with `imem_req_addr`=RESET_PC in the first cycle after `rst` deasserts.

Configuration
REQ-032 Macro IFU_ILLEGAL_CHECK_EN: when defined, SHALL add output `id_illegal` (1 bit) = (`id_instr`[1:0] != 2'b11) | (`id_instr` == 0), valid with `id_valid`.
REQ-033 When IFU_ILLEGAL_CHECK_EN is undefined, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package ifu_pkg SHALL hold XLEN=32, INSTR_BYTES=4, default RESET_PC, and the fetch-entry typedef {pc, instr}.
REQ-035 SHALL use one sub-module, fetch_fifo: parameterised DEPTH sync FIFO with push, pop, flush, full, empty and count, used for both the buffer and the addr queue.

Verification
REQ-036 Bench SHALL cover: reset release, memory always ready, 1-cycle latency -> addresses 0,4,8,... issued; `id_pc` 0,4,8 on consecutive cycles with `id_ready`=1.
REQ-037 Bench SHALL cover: `id_ready`=0 for 10 cycles -> exactly 2 requests issued then `imem_req_valid`=0; `id_pc` held at 0; resumes with no loss or duplication.
REQ-038 Bench SHALL cover: redirect to 32'h0000_0102 with 2 in flight -> both responses dropped; next `id_pc`=32'h0000_0100; next request addr 0x100.
REQ-039 Bench SHALL cover: redirect in the same cycle as `imem_rsp_valid` and `id_ready` -> that response dropped, drop count=in-flight-1, no `id_valid` that cycle.
REQ-040 Bench SHALL cover: RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 Bench SHALL cover, with IFU_ILLEGAL_CHECK_EN: response 32'h0000_0000 -> `id_illegal`=1; response 32'h0000_0013 -> `id_illegal`=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FULL,
    ST_DRAIN
  } ifu_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; serves as both the
// instruction buffer and the outstanding-request address queue.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO may still take a push in the same cycle it is popped
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, buffers responses for
// decode, and discards stale responses after a redirect.
// Optional output id_illegal is built when IFU_ILLEGAL_CHECK_EN is defined.
//
// state    | meaning
// IDLE     | nothing buffered or in flight
// FETCH    | buffered + in-flight below DEPTH, requests allowed
// FULL     | buffered + in-flight at DEPTH, requests held off
// DRAIN    | stale responses still owed by memory; requests allowed
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
`ifdef IFU_ILLEGAL_CHECK_EN
  , output logic          id_illegal
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  ifu_state_e      state_q;
  ifu_state_e      state_d;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_d;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   drop_d;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   buf_count_d;
  logic [CW-1:0]   aq_count;
  logic [OW-1:0]   occ_d;
  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            buf_push;
  logic            buf_pop;
  logic            buf_full;
  logic            buf_empty;
  logic            aq_full;
  logic            aq_empty;
  logic [XLEN-1:0] aq_head;
  fetch_entry_t    buf_wdata;
  fetch_entry_t    buf_head;
  logic            unused_fifo_flags;

  assign imem_req_valid = !rst && !redirect_valid && (state_q != ST_FULL);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop == '0);
  assign rsp_drop       = imem_rsp_valid && (drop != '0);
  assign buf_push       = rsp_keep && !redirect_valid;
  assign id_valid       = !rst && !buf_empty && !redirect_valid;
  assign buf_pop        = id_valid && id_ready;
  assign id_instr       = buf_head.instr;
  assign id_pc          = buf_head.pc;

  assign buf_wdata.pc    = aq_head;
  assign buf_wdata.instr = imem_rsp_data;

  assign unused_fifo_flags = ^{buf_full, aq_full, aq_empty, aq_count};

`ifdef IFU_ILLEGAL_CHECK_EN
  assign id_illegal = (id_instr[1:0] != 2'b11) || (id_instr == '0);
`endif

  fetch_fifo #(.DEPTH(DEPTH), .W(XLEN), .CW(CW)) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .wdata (pc),
    .rdata (aq_head),
    .full  (aq_full),
    .empty (aq_empty),
    .count (aq_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t)), .CW(CW)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .wdata (buf_wdata),
    .rdata (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // every outstanding request is owed a response, so a redirect must drop
  // all of them except one arriving this very cycle
  always_comb begin
    inflight_d  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d      = drop;
    buf_count_d = buf_count + CW'(buf_push) - CW'(buf_pop);
    if (redirect_valid) begin
      drop_d      = inflight - CW'(imem_rsp_valid);
      buf_count_d = '0;
    end else if (rsp_drop) begin
      drop_d = drop - 1'b1;
    end
    occ_d = OW'(buf_count_d) + OW'(inflight_d);
    state_d = ST_FETCH;
    if (occ_d >= OW'(DEPTH))  state_d = ST_FULL;
    else if (drop_d != '0)    state_d = ST_DRAIN;
    else if (occ_d == '0)     state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      if (redirect_valid)  pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)   pc <= pc + XLEN'(INSTR_BYTES);
      inflight <= inflight_d;
      drop     <= drop_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, wrap-around and
// random traffic checked against an epoch-based fetch model.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  logic        w_rst;
  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_id_valid, w_id_ready;
  logic [31:0] w_id_instr, w_id_pc;
`ifdef IFU_ILLEGAL_CHECK_EN
  logic        id_illegal, w_id_illegal;
`endif

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc)
`ifdef IFU_ILLEGAL_CHECK_EN
    , .id_illegal(id_illegal)
`endif
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .id_valid(w_id_valid), .id_ready(w_id_ready),
    .id_instr(w_id_instr), .id_pc(w_id_pc)
`ifdef IFU_ILLEGAL_CHECK_EN
    , .id_illegal(w_id_illegal)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory contents; 0x200/0x204 hold a zero word and a legal addi
  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0000_0000;
    if (a == 32'h0000_0204) return 32'h0000_0013;
    return (a * 32'd3) ^ 32'h1234_5673;
  endfunction

  // memory model: in-order responses, each tagged with the fetch epoch
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          lat = 1;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_req_pc = 32'h0;

  // check this cycle against the model, then clock and drive memory response
  task automatic advance();
    logic        exp_rv, exp_iv;
    logic [31:0] ei;
    int          due;
    mreq_t       e;
    #1;
    if (rst) begin
      check("rst_req_valid", imem_req_valid, 1'b0);
      check("rst_id_valid", id_valid, 1'b0);
      mq.delete();
      buffered   = 0;
      epoch++;
      exp_pc     = 32'h0;
      exp_req_pc = 32'h0;
    end else begin
      exp_rv = !redirect_valid && ((mq.size() + buffered) < DEPTH);
      exp_iv = !redirect_valid && (buffered > 0);
      check("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) check("req_addr", imem_req_addr, exp_req_pc);
      check("id_valid", id_valid, exp_iv);
      if (exp_iv) begin
        ei = data_of(exp_pc);
        check("id_pc", id_pc, exp_pc);
        check("id_instr", id_instr, ei);
`ifdef IFU_ILLEGAL_CHECK_EN
        check("id_illegal", id_illegal, (ei[1:0] != 2'b11) || (ei == 32'h0));
`endif
        if (id_ready) begin
          buffered--;
          exp_pc += 32'd4;
        end
      end
      if (imem_rsp_valid && mq.size() > 0) begin
        if (mq[0].epoch == epoch && !redirect_valid) buffered++;
        void'(mq.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + lat;
        if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
        e.addr = imem_req_addr; e.epoch = epoch; e.due = due;
        mq.push_back(e);
      end
      if (exp_rv && imem_req_ready) exp_req_pc += 32'd4;
      if (redirect_valid) begin
        buffered   = 0;
        epoch++;
        exp_pc     = {redirect_pc[31:2], 2'b00};
        exp_req_pc = {redirect_pc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        exp_rv;
    logic [31:0] exp_ra;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic rdy, input logic rd,
                              input logic [31:0] rpc, input int l,
                              input logic erv, input logic [31:0] era,
                              input logic eiv, input logic [31:0] eipc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.redir = rd; v.rpc = rpc; v.lat = l;
    v.exp_rv = erv; v.exp_ra = era; v.exp_iv = eiv; v.exp_ipc = eipc;
    vecs.push_back(v);
  endfunction

  logic [31:0] waddr[$];
  logic [31:0] wpc[$];
  logic [31:0] wexp_addr[3];
  logic        wfire;
  logic [31:0] wlast;
  logic        seen0, seen1;

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    w_rst = 1'b1; w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
    w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_id_ready = 1'b1;

    // backpressure from reset: two requests, id_pc held at 0, then resume
    add(1,0,0,0,1, 0,0,0,0);
    add(1,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,1, 1,32'h0,0,0);
    add(0,0,0,0,1, 1,32'h4,0,0);
    for (int i = 0; i < 8; i++) add(0,0,0,0,1, 0,0,1,32'h0);
    add(0,1,0,0,1, 0,0,1,32'h0);
    add(0,1,0,0,1, 1,32'h8,1,32'h4);
    add(0,1,0,0,1, 1,32'hC,0,0);
    add(0,1,0,0,1, 0,0,1,32'h8);
    add(0,1,0,0,1, 1,32'h10,1,32'hC);
    add(0,1,0,0,1, 1,32'h14,0,0);
    // redirect to 0x102 with two requests outstanding (latency 3)
    add(1,0,0,0,3, 0,0,0,0);
    add(1,0,0,0,3, 0,0,0,0);
    add(0,1,0,0,3, 1,32'h0,0,0);
    add(0,1,0,0,3, 1,32'h4,0,0);
    add(0,1,1,32'h102,3, 0,0,0,0);
    add(0,1,0,0,3, 0,0,0,0);
    add(0,1,0,0,3, 1,32'h100,0,0);
    add(0,1,0,0,3, 1,32'h104,0,0);
    add(0,1,0,0,3, 0,0,0,0);
    add(0,1,0,0,3, 0,0,0,0);
    add(0,1,0,0,3, 0,0,1,32'h100);
    add(0,1,0,0,3, 1,32'h108,1,32'h104);
    // redirect coinciding with a response and a ready decoder (latency 2)
    add(1,0,0,0,2, 0,0,0,0);
    add(1,0,0,0,2, 0,0,0,0);
    add(0,1,0,0,2, 1,32'h0,0,0);
    add(0,1,0,0,2, 1,32'h4,0,0);
    add(0,1,0,0,2, 0,0,0,0);
    add(0,1,1,32'h40,2, 0,0,0,0);
    add(0,1,0,0,2, 1,32'h40,0,0);
    add(0,1,0,0,2, 1,32'h44,0,0);
    add(0,1,0,0,2, 0,0,0,0);
    add(0,1,0,0,2, 0,0,1,32'h40);
    add(0,1,0,0,2, 1,32'h48,1,32'h44);

    // wrap-around at the top of the address space
    wexp_addr[0] = 32'hFFFF_FFF8; wexp_addr[1] = 32'hFFFF_FFFC; wexp_addr[2] = 32'h0000_0000;
    @(posedge clk); @(posedge clk); #1;
    w_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (w_req_valid) waddr.push_back(w_req_addr);
      if (w_id_valid) wpc.push_back(w_id_pc);
      wfire = w_req_valid;
      wlast = w_req_addr;
      @(posedge clk); #1;
      w_rsp_valid = wfire;
      w_rsp_data  = wlast;
    end
    w_rst = 1'b1; w_rsp_valid = 1'b0;
    check("wrap_req_count", 32'(waddr.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < waddr.size()) check($sformatf("wrap_req_addr%0d", i), waddr[i], wexp_addr[i]);
    check("wrap_pc_count", 32'(wpc.size() >= 2), 32'd1);
    for (int i = 0; i < 2; i++)
      if (i < wpc.size()) check($sformatf("wrap_id_pc%0d", i), wpc[i], wexp_addr[i]);

    // directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; id_ready = vecs[i].rdy; redirect_valid = vecs[i].redir;
      redirect_pc = vecs[i].rpc; lat = vecs[i].lat; imem_req_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_ra);
      check($sformatf("vec%0d_id_valid", i), id_valid, vecs[i].exp_iv);
      if (vecs[i].exp_iv) check($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].exp_ipc);
      advance();
    end

    // random traffic against the model
    rst = 1'b1; redirect_valid = 1'b0; advance(); advance();
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 599) == 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      advance();
    end

`ifdef IFU_ILLEGAL_CHECK_EN
    rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;
    advance(); advance();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    advance();
    redirect_valid = 1'b0;
    seen0 = 1'b0; seen1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (id_valid && id_pc == 32'h0000_0200) begin
        check("illegal_zero_word", id_illegal, 1'b1); seen0 = 1'b1;
      end
      if (id_valid && id_pc == 32'h0000_0204) begin
        check("illegal_addi_word", id_illegal, 1'b0); seen1 = 1'b1;
      end
      advance();
    end
    check("illegal_seen_200", seen0, 1'b1);
    check("illegal_seen_204", seen1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
